// File: rtl/vending_machine_param.sv
// ---------------------------------------------------------------------------
// vending_machine_param
//
// Purpose:
//   Parametrised vending controller. Accumulates coins into a running credit
//   register, serves NUM_PROD products priced from the PRICES table, and
//   returns change as a count of 10rs units. Supports cancel/refund and
//   rejects coins that would push the credit above MAX_CREDIT.
//   Sits between the coin acceptor front end and the dispense/change
//   actuators. Every output is driven straight from a register.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   coin_valid   in   coin present this cycle
//   coin[2:0]    in   coin code 001..101 = 1..5 units; 000/110/111 are invalid
//   sel_valid    in   product selection strobe
//   sel          in   product index (SEL_W bits)
//   cancel       in   refund request
//   vend         out  one-cycle dispense pulse
//   vend_id      out  product being dispensed (0 when vend=0)
//   change_valid out  one-cycle change pulse
//   change       out  change in units (0 when change_valid=0)
//   credit       out  current credit in units
//   busy         out  high during the VEND/REFUND cycle; inputs are ignored
//   coin_reject  out  one-cycle pulse: the coin was not accepted
//   sel_deny     out  one-cycle pulse: the selection was refused
// ---------------------------------------------------------------------------
module vending_machine_param #(
    parameter int NUM_PROD   = 4,
    parameter int SEL_W      = 2,
    parameter int CREDIT_W   = 8,
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES = {8'd4, 8'd3, 8'd2, 8'd1},
    parameter int MAX_CREDIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [2:0]          coin,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel,
    input  logic                cancel,
    output logic                vend,
    output logic [SEL_W-1:0]    vend_id,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                coin_reject,
    output logic                sel_deny
);

    localparam int             LP_SLOTS = 2 ** SEL_W;
    localparam logic [CREDIT_W:0] LP_MAX = (CREDIT_W + 1)'(MAX_CREDIT);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_VEND    = 2'd2,
        S_REFUND  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CREDIT_W-1:0] r_credit,       w_credit_next;
    logic                r_vend,         w_vend_next;
    logic [SEL_W-1:0]    r_vend_id,      w_vend_id_next;
    logic                r_change_valid, w_change_valid_next;
    logic [CREDIT_W-1:0] r_change,       w_change_next;
    logic                r_busy,         w_busy_next;
    logic                r_coin_reject,  w_coin_reject_next;
    logic                r_sel_deny,     w_sel_deny_next;

    // Price table expanded to every encodable sel value. Slots beyond
    // NUM_PROD are flagged out of range so sel never indexes past PRICES.
    logic [CREDIT_W-1:0] w_price_tbl [LP_SLOTS];
    logic [LP_SLOTS-1:0] w_in_range;

    generate
        for (genvar gi = 0; gi < LP_SLOTS; gi++) begin : g_price
            if (gi < NUM_PROD) begin : g_real
                assign w_price_tbl[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
                assign w_in_range[gi]  = 1'b1;
            end else begin : g_unused
                assign w_price_tbl[gi] = '0;
                assign w_in_range[gi]  = 1'b0;
            end
        end
    endgenerate

    // Coin decode: value in units plus a validity flag.
    logic [CREDIT_W:0] w_coin_val;
    logic              w_coin_ok;

    always_comb begin
        w_coin_val = '0;
        w_coin_ok  = 1'b1;
        case (coin)
            3'b001:  w_coin_val = (CREDIT_W + 1)'(1);
            3'b010:  w_coin_val = (CREDIT_W + 1)'(2);
            3'b011:  w_coin_val = (CREDIT_W + 1)'(3);
            3'b100:  w_coin_val = (CREDIT_W + 1)'(4);
            3'b101:  w_coin_val = (CREDIT_W + 1)'(5);
            default: w_coin_ok  = 1'b0;
        endcase
    end

    // One extra bit on the sum so an over-credit coin can never wrap round
    // into a small, seemingly acceptable value.
    logic [CREDIT_W:0]   w_sum;
    logic [CREDIT_W-1:0] w_price;
    logic                w_sel_ok;

    assign w_sum    = {1'b0, r_credit} + w_coin_val;
    assign w_price  = w_price_tbl[sel];
    assign w_sel_ok = w_in_range[sel] && (r_credit >= w_price);

    always_comb begin
        w_state_next        = r_state;
        w_credit_next       = r_credit;
        w_vend_next         = 1'b0;
        w_vend_id_next      = '0;
        w_change_valid_next = 1'b0;
        w_change_next       = '0;
        w_busy_next         = 1'b0;
        w_coin_reject_next  = 1'b0;
        w_sel_deny_next     = 1'b0;

        case (r_state)
            S_VEND, S_REFUND: begin
                // Single busy cycle; anything presented now is dropped.
                w_state_next  = S_IDLE;
                w_credit_next = '0;
            end
            default: begin
                // cancel outranks the other inputs even when it has nothing
                // to refund, so a same-cycle sel/coin is still dropped.
                if (cancel) begin
                    if (r_credit != '0) begin
                        w_state_next        = S_REFUND;
                        w_change_valid_next = 1'b1;
                        w_change_next       = r_credit;
                        w_credit_next       = '0;
                        w_busy_next         = 1'b1;
                    end
                end else if (sel_valid) begin
                    if (w_sel_ok) begin
                        w_state_next        = S_VEND;
                        w_vend_next         = 1'b1;
                        w_vend_id_next      = sel;
                        w_change_valid_next = 1'b1;
                        w_change_next       = r_credit - w_price;
                        w_credit_next       = '0;
                        w_busy_next         = 1'b1;
                    end else begin
                        w_sel_deny_next = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (!w_coin_ok || (w_sum > LP_MAX)) begin
                        w_coin_reject_next = 1'b1;
                    end else begin
                        w_credit_next = w_sum[CREDIT_W-1:0];
                        w_state_next  = S_COLLECT;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_credit       <= '0;
            r_vend         <= 1'b0;
            r_vend_id      <= '0;
            r_change_valid <= 1'b0;
            r_change       <= '0;
            r_busy         <= 1'b0;
            r_coin_reject  <= 1'b0;
            r_sel_deny     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_credit       <= w_credit_next;
            r_vend         <= w_vend_next;
            r_vend_id      <= w_vend_id_next;
            r_change_valid <= w_change_valid_next;
            r_change       <= w_change_next;
            r_busy         <= w_busy_next;
            r_coin_reject  <= w_coin_reject_next;
            r_sel_deny     <= w_sel_deny_next;
        end
    end

    assign vend         = r_vend;
    assign vend_id      = r_vend_id;
    assign change_valid = r_change_valid;
    assign change       = r_change;
    assign credit       = r_credit;
    assign busy         = r_busy;
    assign coin_reject  = r_coin_reject;
    assign sel_deny     = r_sel_deny;

endmodule

// File: tb/tb_vending_machine_param.sv
// ---------------------------------------------------------------------------
// tb_vending_machine_param
//
// Directed bench for vending_machine_param. Two instances share the input
// stimulus: u_dut uses the default 4-product table (1/2/3/4 units), u_dut3
// is a 3-product build (1/2/3 units) used to show that an out-of-range sel
// is refused. One task per scenario, each with inline comparisons.
// ---------------------------------------------------------------------------
module tb_vending_machine_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       coin_valid = 1'b0;
    logic [2:0] coin = 3'd0;
    logic       sel_valid = 1'b0;
    logic [1:0] sel = 2'd0;
    logic       cancel = 1'b0;

    logic       vend,  vend3;
    logic [1:0] vend_id, vend_id3;
    logic       change_valid, change_valid3;
    logic [7:0] change, change3;
    logic [7:0] credit, credit3;
    logic       busy, busy3;
    logic       coin_reject, coin_reject3;
    logic       sel_deny, sel_deny3;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    vending_machine_param u_dut (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
        .vend(vend), .vend_id(vend_id), .change_valid(change_valid),
        .change(change), .credit(credit), .busy(busy),
        .coin_reject(coin_reject), .sel_deny(sel_deny)
    );

    vending_machine_param #(
        .NUM_PROD(3), .SEL_W(2), .CREDIT_W(8),
        .PRICES({8'd3, 8'd2, 8'd1}), .MAX_CREDIT(15)
    ) u_dut3 (
        .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin),
        .sel_valid(sel_valid), .sel(sel), .cancel(cancel),
        .vend(vend3), .vend_id(vend_id3), .change_valid(change_valid3),
        .change(change3), .credit(credit3), .busy(busy3),
        .coin_reject(coin_reject3), .sel_deny(sel_deny3)
    );

    // Apply one cycle of inputs; return #1 after the capturing edge with the
    // inputs released, so the caller sees that cycle's registered outputs.
    task automatic drive(input logic r, input logic cv, input logic [2:0] c,
                         input logic sv, input logic [1:0] s, input logic cn);
        rst = r; coin_valid = cv; coin = c; sel_valid = sv; sel = s; cancel = cn;
        @(posedge clk);
        #1;
        rst = 1'b0; coin_valid = 1'b0; coin = 3'd0;
        sel_valid = 1'b0; sel = 2'd0; cancel = 1'b0;
        $display("t=%0t rst=%b coin_v=%b coin=%b sel_v=%b sel=%0d cancel=%b -> credit=%0d vend=%b id=%0d chg_v=%b chg=%0d busy=%b rej=%b deny=%b",
                 $time, r, cv, c, sv, s, cn, credit, vend, vend_id,
                 change_valid, change, busy, coin_reject, sel_deny);
    endtask

    task automatic test_reset;
        drive(1, 0, 3'd0, 0, 2'd0, 0);
        vectors++; if (credit !== 8'd0) begin miscompares++; $display("FAIL reset_credit got %0d want 0", credit); end
        vectors++; if ({vend, vend_id, change_valid, change, busy, coin_reject, sel_deny} !== 15'd0) begin
            miscompares++; $display("FAIL reset_outputs got %b want all zero",
                {vend, vend_id, change_valid, change, busy, coin_reject, sel_deny}); end
    endtask

    task automatic test_vend_with_change;
        drive(0, 1, 3'b011, 0, 2'd0, 0);
        vectors++; if (credit !== 8'd3) begin miscompares++; $display("FAIL coin30_credit got %0d want 3", credit); end
        drive(0, 0, 3'd0, 1, 2'd0, 0);
        vectors++; if (vend !== 1'b1 || vend_id !== 2'd0) begin
            miscompares++; $display("FAIL vend0 got vend=%b id=%0d want vend=1 id=0", vend, vend_id); end
        vectors++; if (change_valid !== 1'b1 || change !== 8'd2) begin
            miscompares++; $display("FAIL vend0_change got v=%b chg=%0d want v=1 chg=2", change_valid, change); end
        vectors++; if (credit !== 8'd0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL vend0_busy got credit=%0d busy=%b want 0/1", credit, busy); end
        drive(0, 0, 3'd0, 0, 2'd0, 0);
        vectors++; if (busy !== 1'b0 || vend !== 1'b0 || change_valid !== 1'b0 || change !== 8'd0) begin
            miscompares++; $display("FAIL vend0_idle got busy=%b vend=%b chg_v=%b chg=%0d want all 0",
                busy, vend, change_valid, change); end
    endtask

    task automatic test_deny_then_exact;
        drive(0, 1, 3'b001, 0, 2'd0, 0);
        drive(0, 1, 3'b001, 0, 2'd0, 0);
        vectors++; if (credit !== 8'd2) begin miscompares++; $display("FAIL two_coins_credit got %0d want 2", credit); end
        drive(0, 0, 3'd0, 1, 2'd2, 0);
        vectors++; if (sel_deny !== 1'b1 || credit !== 8'd2 || vend !== 1'b0) begin
            miscompares++; $display("FAIL deny_sel2 got deny=%b credit=%0d vend=%b want 1/2/0", sel_deny, credit, vend); end
        drive(0, 1, 3'b001, 0, 2'd0, 0);
        vectors++; if (sel_deny !== 1'b0 || credit !== 8'd3) begin
            miscompares++; $display("FAIL deny_pulse_len got deny=%b credit=%0d want 0/3", sel_deny, credit); end
        drive(0, 0, 3'd0, 1, 2'd2, 0);
        vectors++; if (vend !== 1'b1 || vend_id !== 2'd2 || change_valid !== 1'b1 || change !== 8'd0) begin
            miscompares++; $display("FAIL exact_vend got vend=%b id=%0d chg_v=%b chg=%0d want 1/2/1/0",
                vend, vend_id, change_valid, change); end
        drive(0, 0, 3'd0, 0, 2'd0, 0);
    endtask

    task automatic test_max_credit_and_cancel;
        drive(0, 1, 3'b101, 0, 2'd0, 0);
        drive(0, 1, 3'b101, 0, 2'd0, 0);
        drive(0, 1, 3'b101, 0, 2'd0, 0);
        vectors++; if (credit !== 8'd15 || coin_reject !== 1'b0) begin
            miscompares++; $display("FAIL fill_to_max got credit=%0d rej=%b want 15/0", credit, coin_reject); end
        drive(0, 1, 3'b001, 0, 2'd0, 0);
        vectors++; if (coin_reject !== 1'b1 || credit !== 8'd15) begin
            miscompares++; $display("FAIL over_max got rej=%b credit=%0d want 1/15", coin_reject, credit); end
        drive(0, 0, 3'd0, 0, 2'd0, 1);
        vectors++; if (change_valid !== 1'b1 || change !== 8'd15 || busy !== 1'b1 || credit !== 8'd0 || vend !== 1'b0) begin
            miscompares++; $display("FAIL cancel15 got chg_v=%b chg=%0d busy=%b credit=%0d vend=%b want 1/15/1/0/0",
                change_valid, change, busy, credit, vend); end
        drive(0, 0, 3'd0, 0, 2'd0, 0);
        vectors++; if (busy !== 1'b0 || change_valid !== 1'b0) begin
            miscompares++; $display("FAIL cancel15_busy_len got busy=%b chg_v=%b want 0/0", busy, change_valid); end
    endtask

    task automatic test_invalid_and_range;
        drive(0, 1, 3'b110, 0, 2'd0, 0);
        vectors++; if (coin_reject !== 1'b1 || credit !== 8'd0) begin
            miscompares++; $display("FAIL bad_coin got rej=%b credit=%0d want 1/0", coin_reject, credit); end
        drive(0, 0, 3'd0, 1, 2'd3, 0);
        vectors++; if (sel_deny !== 1'b1 || coin_reject !== 1'b0 || credit !== 8'd0) begin
            miscompares++; $display("FAIL sel3_zero_credit got deny=%b rej=%b credit=%0d want 1/0/0",
                sel_deny, coin_reject, credit); end
        vectors++; if (sel_deny3 !== 1'b1 || credit3 !== 8'd0) begin
            miscompares++; $display("FAIL np3_sel3_zero got deny=%b credit=%0d want 1/0", sel_deny3, credit3); end
        drive(0, 1, 3'b100, 0, 2'd0, 0);
        vectors++; if (credit !== 8'd4 || credit3 !== 8'd4) begin
            miscompares++; $display("FAIL coin40 got credit=%0d credit3=%0d want 4/4", credit, credit3); end
        // Enough credit for product 3 in the 4-product build, but product 3
        // does not exist in the 3-product build.
        drive(0, 0, 3'd0, 1, 2'd3, 0);
        vectors++; if (vend !== 1'b1 || vend_id !== 2'd3 || change !== 8'd0) begin
            miscompares++; $display("FAIL vend3 got vend=%b id=%0d chg=%0d want 1/3/0", vend, vend_id, change); end
        vectors++; if (sel_deny3 !== 1'b1 || vend3 !== 1'b0 || credit3 !== 8'd4) begin
            miscompares++; $display("FAIL np3_sel3 got deny=%b vend=%b credit=%0d want 1/0/4", sel_deny3, vend3, credit3); end
        drive(0, 0, 3'd0, 0, 2'd0, 0);
        drive(0, 0, 3'd0, 0, 2'd0, 1);
        vectors++; if (change_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL cancel_zero got chg_v=%b busy=%b want 0/0", change_valid, busy); end
        vectors++; if (change_valid3 !== 1'b1 || change3 !== 8'd4) begin
            miscompares++; $display("FAIL np3_refund got chg_v=%b chg=%0d want 1/4", change_valid3, change3); end
        drive(0, 0, 3'd0, 0, 2'd0, 0);
    endtask

    task automatic test_priority_and_busy;
        drive(0, 1, 3'b100, 0, 2'd0, 0);
        vectors++; if (credit !== 8'd4) begin miscompares++; $display("FAIL prio_setup got credit=%0d want 4", credit); end
        drive(0, 1, 3'b001, 1, 2'd3, 1);
        vectors++; if (change_valid !== 1'b1 || change !== 8'd4 || vend !== 1'b0) begin
            miscompares++; $display("FAIL prio_cancel got chg_v=%b chg=%0d vend=%b want 1/4/0", change_valid, change, vend); end
        vectors++; if (coin_reject !== 1'b0 || sel_deny !== 1'b0) begin
            miscompares++; $display("FAIL prio_dropped got rej=%b deny=%b want 0/0", coin_reject, sel_deny); end
        drive(0, 1, 3'b001, 0, 2'd0, 0);
        vectors++; if (credit !== 8'd0 || coin_reject !== 1'b0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL busy_coin got credit=%0d rej=%b busy=%b want 0/0/0", credit, coin_reject, busy); end
    endtask

    task automatic test_back_to_back_reset;
        drive(0, 1, 3'b011, 0, 2'd0, 0);
        vectors++; if (credit !== 8'd3) begin miscompares++; $display("FAIL pre_reset got credit=%0d want 3", credit); end
        drive(1, 0, 3'd0, 0, 2'd0, 0);
        vectors++; if (credit !== 8'd0 || change_valid !== 1'b0 || change !== 8'd0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL mid_reset got credit=%0d chg_v=%b chg=%0d busy=%b want 0/0/0/0",
                credit, change_valid, change, busy); end
        drive(0, 1, 3'b010, 0, 2'd0, 0);
        vectors++; if (credit !== 8'd2) begin miscompares++; $display("FAIL post_reset_coin got credit=%0d want 2", credit); end
        drive(0, 0, 3'd0, 1, 2'd1, 0);
        vectors++; if (vend !== 1'b1 || vend_id !== 2'd1 || change_valid !== 1'b1 || change !== 8'd0) begin
            miscompares++; $display("FAIL post_reset_vend got vend=%b id=%0d chg_v=%b chg=%0d want 1/1/1/0",
                vend, vend_id, change_valid, change); end
        drive(0, 0, 3'd0, 0, 2'd0, 0);
        vectors++; if (vend !== 1'b0 || vend_id !== 2'd0 || credit !== 8'd0) begin
            miscompares++; $display("FAIL post_vend_idle got vend=%b id=%0d credit=%0d want 0/0/0", vend, vend_id, credit); end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_vend_with_change();
        test_deny_then_exact();
        test_max_credit_and_cancel();
        test_invalid_and_range();
        test_priority_and_busy();
        test_back_to_back_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
